// File: rtl/pcpu_run_ctrl_if.sv
// Host command port of the CPU run/step controller.
// The host (master) presents an op code and step argument with cmd_valid;
// the controller (slave) accepts on the rising edge where cmd_ready is high.
interface pcpu_run_ctrl_if #(
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/pcpu_run_ctrl.sv
// pcpu_run_ctrl: run/step sequencer for the pipelined CPU core.
// Drives the core reset/enable/start lines for free run, N-cycle stepping,
// PC breakpoints, HALT detection and a timed core reset.
// Optional feature: define PCPU_RUN_CTRL_BP_EN to build the PC breakpoint
// comparator; without it RUN ends only on STOP, RESET_CPU or HALT.
module pcpu_run_ctrl #(
  parameter int STEP_W     = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  pcpu_run_ctrl_if.slave       cmd,
  input  logic                 bp_en,
  input  logic [7:0]           bp_addr,
  input  logic [7:0]           cpu_pc,
  input  logic                 cpu_halt,
  output logic                 cpu_reset,
  output logic                 cpu_enable,
  output logic                 cpu_start,
  output logic                 busy,
  output logic [1:0]           stop_cause,
  output logic [15:0]          cycle_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_RSTC, S_ARM, S_RUN, S_STEP} state_e;
  typedef enum logic       {MODE_RUN, MODE_STEP} mode_e;
  typedef enum logic [1:0] {OP_RUN = 2'b00, OP_STEP = 2'b01,
                            OP_STOP = 2'b10, OP_RESET = 2'b11} op_e;
  typedef enum logic [1:0] {SC_NONE = 2'b00, SC_STEP = 2'b01,
                            SC_BP = 2'b10, SC_HALT = 2'b11} cause_e;

  // Counter just wide enough to hold RST_CYCLES-1; it counts down to zero.
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  cause_e            stop_cause_q, stop_cause_d;
  logic [15:0]       cycle_cnt_q, cycle_cnt_d;

  logic cmd_ready_w;
  logic cmd_fire;
  logic bp_hit;
  logic step_last;

`ifdef PCPU_RUN_CTRL_BP_EN
  assign bp_hit = bp_en && (cpu_pc == bp_addr);
`else
  // No comparator: the breakpoint inputs are deliberately left unconnected.
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, cpu_pc};
  assign bp_hit    = 1'b0;
`endif

  assign cmd_fire  = cmd.cmd_valid && cmd_ready_w;
  assign step_last = (step_cnt_q == STEP_W'(1));

  // State register and all controller counters.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_RUN;
      step_cnt_q   <= '0;
      rst_cnt_q    <= '0;
      stop_cause_q <= SC_NONE;
      cycle_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      step_cnt_q   <= step_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      stop_cause_q <= stop_cause_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  // Next-state logic: command handling, exit priority and counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    mode_d       = mode_q;
    step_cnt_d   = step_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    stop_cause_d = stop_cause_q;
    cycle_cnt_d  = cycle_cnt_q;

    if ((state_q == S_RUN || state_q == S_STEP) && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              state_d      = S_ARM;
              mode_d       = MODE_RUN;
              stop_cause_d = SC_NONE;
              cycle_cnt_d  = '0;
            end
            OP_STEP: begin
              // A zero-length step does nothing at all.
              if (cmd.cmd_arg != '0) begin
                state_d      = S_ARM;
                mode_d       = MODE_STEP;
                step_cnt_d   = cmd.cmd_arg;
                stop_cause_d = SC_NONE;
                cycle_cnt_d  = '0;
              end
            end
            OP_RESET: begin
              state_d      = S_RSTC;
              rst_cnt_d    = RST_LOAD;
              stop_cause_d = SC_NONE;
            end
            default: ;  // STOP while idle is a no-op
          endcase
        end
      end

      S_RSTC: begin
        if (rst_cnt_q == '0) state_d = S_IDLE;
        else                 rst_cnt_d = rst_cnt_q - RST_W'(1);
      end

      S_ARM: begin
        state_d = (mode_q == MODE_STEP) ? S_STEP : S_RUN;
      end

      S_RUN, S_STEP: begin
        if (state_q == S_STEP) step_cnt_d = step_cnt_q - STEP_W'(1);
        // RUN/STEP commands seen here are accepted and dropped.
        if (cmd_fire && cmd.cmd_op == OP_RESET) begin
          state_d      = S_RSTC;
          rst_cnt_d    = RST_LOAD;
          stop_cause_d = SC_NONE;
        end else if (cmd_fire && cmd.cmd_op == OP_STOP) begin
          state_d = S_IDLE;
        end else if (cpu_halt) begin
          state_d      = S_IDLE;
          stop_cause_d = SC_HALT;
        end else if (state_q == S_RUN && bp_hit) begin
          state_d      = S_IDLE;
          stop_cause_d = SC_BP;
        end else if (state_q == S_STEP && step_last) begin
          state_d      = S_IDLE;
          stop_cause_d = SC_STEP;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only; no input reaches an output.
  always_comb begin
    cpu_reset   = 1'b0;
    cpu_enable  = 1'b0;
    cpu_start   = 1'b0;
    cmd_ready_w = 1'b0;
    case (state_q)
      S_IDLE: cmd_ready_w = 1'b1;
      S_RSTC: cpu_reset   = 1'b1;
      S_ARM: begin
        cpu_enable = 1'b1;
        cpu_start  = 1'b1;
      end
      S_RUN: begin
        cpu_enable  = 1'b1;
        cmd_ready_w = 1'b1;
      end
      S_STEP: begin
        // Dropping enable in the last step cycle lets the core finish its Nth advance.
        cpu_enable  = !step_last;
        cmd_ready_w = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd.cmd_ready = cmd_ready_w;
  assign busy          = (state_q != S_IDLE);
  assign stop_cause    = stop_cause_q;
  assign cycle_cnt     = cycle_cnt_q;

endmodule

// File: doc/pcpu_run_ctrl.md
# pcpu_run_ctrl

Run/step controller that sequences the pipelined CPU core from a host command port. It drives the core's `reset`, `enable` and `start` inputs to provide free run, exact N-cycle single-stepping, PC breakpoints, HALT detection and timed core reset. It sits between the board/debug host logic and the CPU core, and observes the core's `i_addr` and a decoded HALT-retired flag.

## Interface

Parameters:
- `STEP_W`, default 8: width of the step count.
- `RST_CYCLES`, default 2: number of cycles `cpu_reset` is held high (≥1).

Ports:
- `clock`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: command accepted on the rising edge when both `cmd_valid` and `cmd_ready` are high.
- `cmd_op`, in, 2: command code. 00 RUN, 01 STEP, 10 STOP, 11 RESET_CPU.
- `cmd_arg`, in, STEP_W: step count N for STEP.
- `bp_en`, in, 1: breakpoint enable.
- `bp_addr`, in, 8: breakpoint PC.
- `cpu_pc`, in, 8: core `i_addr`.
- `cpu_halt`, in, 1: core write-back opcode is HALT.
- `cpu_reset`, out, 1: to core `reset`.
- `cpu_enable`, out, 1: to core `enable`.
- `cpu_start`, out, 1: to core `start`.
- `busy`, out, 1: state is not IDLE.
- `stop_cause`, out, 2: 00 none, 01 step done, 10 breakpoint, 11 halt.
- `cycle_cnt`, out, 16: number of cycles spent in RUN or STEP.

## Operation

States: IDLE, RSTC, ARM, RUN, STEP.

- **IDLE:** all `cpu_*` outputs are 0, `cmd_ready`=1.
  - RUN → ARM with mode=run.
  - STEP with N≠0 → ARM with mode=step, step counter loaded with N.
  - STEP with N=0 is a no-op.
  - STOP is a no-op.
  - RESET_CPU → RSTC.
- **RSTC:** `cpu_reset`=1, `cmd_ready`=0. A counter runs for RST_CYCLES cycles, then the state returns to IDLE. On entry, `stop_cause` is cleared to 00.
- **ARM:** exactly one cycle, with `cpu_enable`=1, `cpu_start`=1, `cmd_ready`=0. The next state is RUN or STEP according to mode.
- **RUN:** `cpu_enable`=1, `cmd_ready`=1.
- **STEP:** `cpu_enable` = (counter ≠ 1). The counter decrements every cycle. When the counter reaches 1, the next state is IDLE with `stop_cause`=01.
  - The enable drop in the counter=1 cycle lets the core complete its final advance and fall to idle.
  - The core therefore performs exactly N pipeline advances.
- **Exits from RUN/STEP**, in priority order (first match wins, evaluated each cycle):
  1. RESET_CPU command → RSTC.
  2. STOP command → IDLE, `stop_cause` unchanged.
  3. `cpu_halt`=1 → IDLE, `stop_cause`=11.
  4. RUN only: `bp_en` high and `cpu_pc`==`bp_addr` → IDLE, `stop_cause`=10.
  5. STEP counter=1 → IDLE, `stop_cause`=01.
- RUN and STEP commands received while in RUN/STEP are accepted and discarded.
- Accepting RUN or STEP clears `stop_cause` to 00 and `cycle_cnt` to 0.
- `cycle_cnt` increments in every RUN or STEP cycle and saturates at 0xFFFF.

## Timing

- **Reset:** asynchronous. State=IDLE; `cpu_reset`, `cpu_enable`, `cpu_start`, `busy` = 0; `stop_cause`=00; `cycle_cnt`=0; `cmd_ready`=1 (combinational from IDLE).
- **Output decode:** all `cpu_*`, `busy` and `cmd_ready` are decoded from registered state and counter. No input-to-output combinational path exists.
- **Command latency:** a command accepted on edge t appears in state/outputs in cycle t+1.
- **Breakpoint stop:** match seen in cycle k gives IDLE in cycle k+1. The core completes one final advance at the end of cycle k+1 because it sees `enable`=0 in that cycle.
- **HALT stop:** the core stops itself. The controller reaches IDLE one cycle after `cpu_halt` rises.
- **Step count:** a STEP of N occupies 1 (ARM) + N cycles. `busy` falls in the cycle after the last STEP cycle.
- **Reset mid-operation:** asserting `reset` in any state returns to IDLE immediately. `cpu_reset` is not pulsed.

## Configuration

- **`PCPU_RUN_CTRL_BP_EN` defined:** breakpoint compare logic is present and operates as described under Operation.
- **`PCPU_RUN_CTRL_BP_EN` undefined:**
  - `bp_en`, `bp_addr` and `cpu_pc` are ignored, and no comparator is built.
  - RUN ends only on STOP, RESET_CPU or HALT.
  - `stop_cause`=10 is never produced.

## Test plan

- **Reset release:** `reset` 1→0 → `cmd_ready`=1, `busy`=0, `cpu_enable`=0, `stop_cause`=00, `cycle_cnt`=0.
- **STEP N=3:** `cpu_enable` high for the ARM cycle and 2 STEP cycles, then low in the 3rd STEP cycle; `cpu_start` high only in ARM; core PC advances by exactly 3; `stop_cause`=01. Repeat with STEP N=0 → no state change.
- **RUN with breakpoint:** `bp_en`=1, `bp_addr`=0x05, straight-line code → IDLE one cycle after `cpu_pc`==0x05; `stop_cause`=10. Rebuilt without the macro → RUN continues past 0x05.
- **RUN to HALT:** HALT at address 0x04 → IDLE one cycle after `cpu_halt`; `stop_cause`=11; `cycle_cnt` equals the number of RUN cycles.
- **Simultaneous events:** STOP command and `cpu_halt` in the same cycle → IDLE with `stop_cause` unchanged (00). RESET_CPU during RUN → `cpu_reset` high for exactly 2 cycles and `cmd_ready`=0 during them.
- **Async reset mid-STEP:** N=200, `reset` pulsed mid-count → outputs return to reset values immediately.
